vliw_bundle_loader: RTL and testbench

Program loader that fills the processor's 192-bit VLIW instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and packs each six consecutive words into one bundle, one word per issue slot. It writes each completed bundle to consecutive instruction-memory addresses. It holds the core in reset/stall (`cpu_hold`) while a load session is active.

---
 rtl/vliw_bundle_loader.sv | 126 ++++++++++++
 tb/tb_vliw_bundle_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_bundle_loader.sv
`timescale 1ns/1ps
// VLIW program loader: packs a stream of instruction words into bundles
// (one word per issue slot) and writes each bundle to consecutive
// instruction-memory addresses, holding the core while a session runs.
module vliw_bundle_loader #(
    parameter int SLOTS  = 6,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         num_bundles,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [WORD_W-1:0]       in_word,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [SLOTS*WORD_W-1:0] wr_data,
    output logic                    busy,
    output logic                    cpu_hold,
    output logic                    done,
    output logic [ADDR_W:0]         loaded
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [ADDR_W:0]   ONE_LEFT  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                 state;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W:0]        remaining;
    logic [SLOT_W-1:0]      slot;
    logic [WORD_W-1:0]      buffer [SLOTS];
    logic [SLOTS*WORD_W-1:0] bundle;

    // Complete bundle as it will look once the incoming word lands in its slot.
    always_comb begin
        // NOTE: defaulting every always_comb target first keeps synthesis from inferring a latch.
        bundle = '0;
        for (int k = 0; k < SLOTS; k++) begin
            bundle[k*WORD_W +: WORD_W] = (slot == SLOT_W'(k)) ? in_word : buffer[k];
        end
    end

    // Session control, slot packing and the registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            slot      <= '0;
            // NOTE: the bundle buffer is reset so no word of an interrupted session can leak into a later bundle.
            buffer    <= '{default: '0};
            wr_addr   <= '0;
            wr_data   <= '0;
            loaded    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= num_bundles;
                        loaded    <= '0;
                        slot      <= '0;
                        buffer    <= '{default: '0};
                        state     <= (num_bundles == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        // Partial bundle is dropped, including a word offered this cycle.
                        slot  <= '0;
                        state <= IDLE;
                    end else if (in_valid) begin
                        buffer[slot] <= in_word;
                        if (slot == LAST_SLOT) begin
                            slot    <= '0;
                            wr_addr <= addr;
                            wr_data <= bundle;
                            state   <= WRITE;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // The strobe is already on the bus this cycle, so it counts even if aborted.
                    addr      <= addr + 1'b1;
                    loaded    <= loaded + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (abort) begin
                        state <= IDLE;
                    end else if (remaining == ONE_LEFT) begin
                        state <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register alone.
    assign in_ready = (state == LOAD);
    assign wr_en    = (state == WRITE);
    assign busy     = (state == LOAD) || (state == WRITE);
    assign cpu_hold = busy;
    assign done     = (state == DONE);

endmodule

// File: tb/tb_vliw_bundle_loader.sv
`timescale 1ns/1ps
// Directed bench for vliw_bundle_loader: the stimulus thread queues the
// expected bundle writes, an independent monitor pops and compares them.
module tb_vliw_bundle_loader;

    localparam int SLOTS  = 6;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int DATA_W = SLOTS * WORD_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_bundles;
    logic              abort;
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic [ADDR_W:0]   loaded;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors        = 0;
    int  miscompares    = 0;
    int  words_accepted = 0;
    int  done_cnt       = 0;
    int  write_cnt      = 0;

    vliw_bundle_loader #(
        .SLOTS (SLOTS),
        .WORD_W(WORD_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_bundles(num_bundles),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .loaded     (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) begin
            write_cnt++;
            check("in_ready_in_write", DATA_W'(in_ready), DATA_W'(0));
            check("write_expected", DATA_W'(exp_q.size() > 0), DATA_W'(1));
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", DATA_W'(wr_addr), DATA_W'(mon_e.addr));
                check("wr_data", wr_data, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] bundle_of(input logic [WORD_W-1:0] first);
        logic [DATA_W-1:0] b;
        for (int k = 0; k < SLOTS; k++) b[k*WORD_W +: WORD_W] = first + WORD_W'(k);
        return b;
    endfunction

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        start       = 1'b1;
        base_addr   = b;
        num_bundles = n;
        tick();
        start       = 1'b0;
        base_addr   = '0;
        num_bundles = '0;
    endtask

    // Offer one word and hold it until the loader takes it (bounded).
    task automatic send_word(input logic [WORD_W-1:0] w);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_word  = w;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("word_accepted", DATA_W'(acc), DATA_W'(1));
        if (acc) words_accepted++;
    endtask

    task automatic send_bundle(input logic [WORD_W-1:0] first);
        for (int k = 0; k < SLOTS; k++) send_word(first + WORD_W'(k));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check("done_pulse", DATA_W'(done), DATA_W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa0;
        int dc0;
        int wc0;

        rst = 1'b0; start = 1'b0; base_addr = '0; num_bundles = '0;
        abort = 1'b0; in_valid = 1'b0; in_word = '0;
        tick();
        tick();
        check("rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
        check("rst_busy", DATA_W'(busy), DATA_W'(0));
        check("rst_wr_en", DATA_W'(wr_en), DATA_W'(0));
        check("rst_loaded", DATA_W'(loaded), DATA_W'(0));
        check("rst_wr_data", wr_data, DATA_W'(0));
        rst = 1'b1;
        tick();

        // Single bundle: slot 5 lands in the top word.
        push_exp(8'h10, {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11});
        do_start(8'h10, 9'd1);
        check("t1_busy", DATA_W'(busy), DATA_W'(1));
        check("t1_cpu_hold", DATA_W'(cpu_hold), DATA_W'(1));
        check("t1_in_ready", DATA_W'(in_ready), DATA_W'(1));
        send_word(32'h11); send_word(32'h22); send_word(32'h33);
        send_word(32'h44); send_word(32'h55); send_word(32'h66);
        check("t1_wr_en_after_6th", DATA_W'(wr_en), DATA_W'(1));
        check("t1_busy_in_write", DATA_W'(busy), DATA_W'(1));
        tick();
        check("t1_done", DATA_W'(done), DATA_W'(1));
        check("t1_busy_done", DATA_W'(busy), DATA_W'(0));
        check("t1_cpu_hold_done", DATA_W'(cpu_hold), DATA_W'(0));
        check("t1_loaded", DATA_W'(loaded), DATA_W'(1));
        tick();
        check("t1_done_one_cycle", DATA_W'(done), DATA_W'(0));

        // Backpressure: valid pattern 1,0,0 across two bundles.
        push_exp(8'h20, bundle_of(32'hA000_0000));
        push_exp(8'h21, bundle_of(32'hA000_0006));
        wa0 = words_accepted;
        do_start(8'h20, 9'd2);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b0;
            tick();
            tick();
            send_word(32'hA000_0000 + WORD_W'(i));
        end
        wait_done(20);
        check("t2_words", DATA_W'(words_accepted - wa0), DATA_W'(12));
        check("t2_loaded", DATA_W'(loaded), DATA_W'(2));
        tick();

        // Address wrap 0xFF -> 0x00 -> 0x01.
        push_exp(8'hFF, bundle_of(32'hC000_0000));
        push_exp(8'h00, bundle_of(32'hC000_0010));
        push_exp(8'h01, bundle_of(32'hC000_0020));
        do_start(8'hFF, 9'd3);
        send_bundle(32'hC000_0000);
        send_bundle(32'hC000_0010);
        send_bundle(32'hC000_0020);
        wait_done(10);
        check("t3_loaded", DATA_W'(loaded), DATA_W'(3));
        tick();

        // Abort after the 3rd word of the 2nd bundle.
        dc0 = done_cnt;
        push_exp(8'h40, bundle_of(32'hD000_0000));
        do_start(8'h40, 9'd3);
        send_bundle(32'hD000_0000);
        send_word(32'hD000_0010); send_word(32'hD000_0011); send_word(32'hD000_0012);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy", DATA_W'(busy), DATA_W'(0));
        check("t4_in_ready", DATA_W'(in_ready), DATA_W'(0));
        check("t4_loaded", DATA_W'(loaded), DATA_W'(1));
        for (int i = 0; i < 5; i++) tick();
        check("t4_no_done", DATA_W'(done_cnt - dc0), DATA_W'(0));
        push_exp(8'h50, bundle_of(32'hE000_0000));
        do_start(8'h50, 9'd1);
        check("t4_restart_busy", DATA_W'(busy), DATA_W'(1));
        send_bundle(32'hE000_0000);
        wait_done(10);
        check("t4_restart_loaded", DATA_W'(loaded), DATA_W'(1));
        tick();

        // Reset during the WRITE cycle: the strobe is visible once, then everything clears.
        push_exp(8'h60, bundle_of(32'hF000_0000));
        do_start(8'h60, 9'd1);
        send_bundle(32'hF000_0000);
        check("t5_in_write", DATA_W'(wr_en), DATA_W'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_in_ready", DATA_W'(in_ready), DATA_W'(0));
        check("t5_wr_en", DATA_W'(wr_en), DATA_W'(0));
        check("t5_busy", DATA_W'(busy), DATA_W'(0));
        check("t5_cpu_hold", DATA_W'(cpu_hold), DATA_W'(0));
        check("t5_done", DATA_W'(done), DATA_W'(0));
        check("t5_wr_addr", DATA_W'(wr_addr), DATA_W'(0));
        check("t5_wr_data", wr_data, DATA_W'(0));
        check("t5_loaded", DATA_W'(loaded), DATA_W'(0));
        // Reset mid-LOAD with a partial bundle, then a fresh session.
        do_start(8'h68, 9'd1);
        send_word(32'hBAD0_0000); send_word(32'hBAD0_0001); send_word(32'hBAD0_0002);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_load_reset_busy", DATA_W'(busy), DATA_W'(0));
        push_exp(8'h70, bundle_of(32'h1234_0000));
        do_start(8'h70, 9'd1);
        send_bundle(32'h1234_0000);
        wait_done(10);
        check("t5_fresh_loaded", DATA_W'(loaded), DATA_W'(1));
        tick();

        // num_bundles = 0: done the cycle after start, no write.
        wc0 = write_cnt;
        do_start(8'h90, 9'd0);
        check("t6_zero_done", DATA_W'(done), DATA_W'(1));
        check("t6_zero_busy", DATA_W'(busy), DATA_W'(0));
        check("t6_zero_wr_en", DATA_W'(wr_en), DATA_W'(0));
        tick();
        check("t6_zero_done_once", DATA_W'(done), DATA_W'(0));
        check("t6_zero_writes", DATA_W'(write_cnt - wc0), DATA_W'(0));
        check("t6_zero_loaded", DATA_W'(loaded), DATA_W'(0));

        // start mid-session is ignored.
        push_exp(8'h30, bundle_of(32'h5500_0000));
        push_exp(8'h31, bundle_of(32'h5500_0006));
        do_start(8'h30, 9'd2);
        send_word(32'h5500_0000); send_word(32'h5500_0001); send_word(32'h5500_0002);
        start       = 1'b1;
        base_addr   = 8'h80;
        num_bundles = 9'd1;
        tick();
        start       = 1'b0;
        base_addr   = '0;
        num_bundles = '0;
        send_word(32'h5500_0003); send_word(32'h5500_0004); send_word(32'h5500_0005);
        send_bundle(32'h5500_0006);
        wait_done(10);
        check("t6_midstart_loaded", DATA_W'(loaded), DATA_W'(2));
        tick();
        tick();

        check("all_writes_seen", DATA_W'(exp_q.size()), DATA_W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
